// File: rtl/video_rect_fill_engine.sv
// Rectangle-fill bus master: clips a CPU-programmed rectangle to the screen and
// writes one colour word per granted cycle into the frame-buffer region.
module video_rect_fill_engine #(
    parameter int unsigned DW   = 9,
    parameter int unsigned HMAX = 640,
    parameter int unsigned VMAX = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        write,
    input  logic        read,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        video_cs,
    output logic        video_wr,
    output logic [20:0] video_addr,
    output logic [31:0] video_wr_data,
    output logic        done_irq
);

    localparam int unsigned CW = 11;
    localparam int unsigned AW = 20;
    localparam int unsigned PW = 19;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [CW-1:0]   xe_q, xe_d, ye_q, ye_d, cx_q, cx_d, cy_q, cy_d;
    logic [DW-1:0]   colour_q, colour_d;
    logic [AW-1:0]   row_base_q, row_base_d;
    logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [20:0]     video_addr_q, video_addr_d;
    logic [31:0]     video_wr_data_q, video_wr_data_d;
    logic            bus_act_q, bus_act_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            cfg_wr_c, busy_c, start_c, abort_c, empty_c;
    logic            accept_c, row_end_c, last_c;
    logic [CW-1:0]   xe_c, ye_c;
    logic [AW-1:0]   row_base_init_c;
    logic            unused_c;

    assign unused_c = ^{read, wr_data};

    assign cfg_wr_c  = cs && write;
    assign busy_c    = (state_q == S_SETUP) || (state_q == S_RUN);
    assign start_c   = cfg_wr_c && (addr == 5'd3) && wr_data[0];
    assign abort_c   = cfg_wr_c && (addr == 5'd3) && wr_data[1];
    assign xe_c      = (x1_q > CW'(HMAX - 1)) ? CW'(HMAX - 1) : x1_q;
    assign ye_c      = (y1_q > CW'(VMAX - 1)) ? CW'(VMAX - 1) : y1_q;
    assign empty_c   = (x0_q > xe_c) || (y0_q > ye_c) ||
                       (x0_q >= CW'(HMAX)) || (y0_q >= CW'(VMAX));
    assign accept_c  = (state_q == S_RUN) && bus_gnt;
    assign row_end_c = (cx_q == xe_q);
    assign last_c    = row_end_c && (cy_q == ye_q);

    // y0*HMAX without a multiplier for the 640-wide screen (512 + 128)
    assign row_base_init_c = (HMAX == 640) ?
                             (AW'(y0_q) << 9) + (AW'(y0_q) << 7) :
                             AW'(y0_q) * AW'(HMAX);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_c) state_d = S_SETUP;
            S_SETUP: begin
                if (abort_c)      state_d = S_IDLE;
                else if (empty_c) state_d = S_DONE;
                else              state_d = S_RUN;
            end
            S_RUN: begin
                if (abort_c)               state_d = S_IDLE;
                else if (accept_c && last_c) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        x0_d            = x0_q;
        y0_d            = y0_q;
        x1_d            = x1_q;
        y1_d            = y1_q;
        xe_d            = xe_q;
        ye_d            = ye_q;
        cx_d            = cx_q;
        cy_d            = cy_q;
        colour_d        = colour_q;
        row_base_d      = row_base_q;
        pix_cnt_d       = pix_cnt_q;
        video_addr_d    = video_addr_q;
        video_wr_data_d = video_wr_data_q;
        done_d          = done_q;

        if (cfg_wr_c && !busy_c) begin
            case (addr)
                5'd0: begin x0_d = wr_data[10:0]; y0_d = wr_data[26:16]; end
                5'd1: begin x1_d = wr_data[10:0]; y1_d = wr_data[26:16]; end
                5'd2: colour_d = wr_data[DW-1:0];
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    done_d    = 1'b0;
                    pix_cnt_d = '0;
                end
            end
            S_SETUP: begin
                xe_d            = xe_c;
                ye_d            = ye_c;
                cx_d            = x0_q;
                cy_d            = y0_q;
                row_base_d      = row_base_init_c;
                video_addr_d    = {1'b1, row_base_init_c + AW'(x0_q)};
                video_wr_data_d = 32'(colour_q);
            end
            S_RUN: begin
                if (accept_c) begin
                    pix_cnt_d = pix_cnt_q + PW'(1);
                    if (row_end_c) begin
                        cx_d         = x0_q;
                        cy_d         = cy_q + CW'(1);
                        row_base_d   = row_base_q + AW'(HMAX);
                        video_addr_d = {1'b1, row_base_q + AW'(HMAX) + AW'(x0_q)};
                    end else begin
                        cx_d         = cx_q + CW'(1);
                        video_addr_d = video_addr_q + 21'd1;
                    end
                end
            end
            default: ;
        endcase

        bus_act_d = (state_d == S_RUN);
        busy_d    = (state_d == S_SETUP) || (state_d == S_RUN);
        if (state_d == S_DONE) done_d = 1'b1;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            x0_q            <= '0;
            y0_q            <= '0;
            x1_q            <= '0;
            y1_q            <= '0;
            xe_q            <= '0;
            ye_q            <= '0;
            cx_q            <= '0;
            cy_q            <= '0;
            colour_q        <= '0;
            row_base_q      <= '0;
            pix_cnt_q       <= '0;
            video_addr_q    <= '0;
            video_wr_data_q <= '0;
            bus_act_q       <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            x0_q            <= x0_d;
            y0_q            <= y0_d;
            x1_q            <= x1_d;
            y1_q            <= y1_d;
            xe_q            <= xe_d;
            ye_q            <= ye_d;
            cx_q            <= cx_d;
            cy_q            <= cy_d;
            colour_q        <= colour_d;
            row_base_q      <= row_base_d;
            pix_cnt_q       <= pix_cnt_d;
            video_addr_q    <= video_addr_d;
            video_wr_data_q <= video_wr_data_d;
            bus_act_q       <= bus_act_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign bus_req       = bus_act_q;
    assign video_cs      = bus_act_q;
    assign video_wr      = bus_act_q;
    assign video_addr    = video_addr_q;
    assign video_wr_data = video_wr_data_q;
    assign done_irq      = done_q;
    assign rd_data       = {11'b0, pix_cnt_q, done_q, busy_q};

endmodule

// File: tb/tb_video_rect_fill_engine.sv
// Directed bench for video_rect_fill_engine: hand-computed addresses, stalls,
// clipping, empty rectangles, abort and mid-run reset.
module tb_video_rect_fill_engine;

    logic        clk = 1'b0;
    logic        reset, cs, write, read, bus_gnt;
    logic [4:0]  addr;
    logic [31:0] wr_data, rd_data, video_wr_data;
    logic        bus_req, video_cs, video_wr, done_irq;
    logic [20:0] video_addr;

    int n_cmp = 0;
    int n_err = 0;

    logic [20:0] t1_addr [4] = '{21'h10320A, 21'h10320B, 21'h10348A, 21'h10348B};
    logic [20:0] t2_addr [4] = '{21'h14AD7E, 21'h14AD7F, 21'h14AFFE, 21'h14AFFF};
    logic [20:0] t4_addr [6] = '{21'h100000, 21'h100001, 21'h100001,
                                 21'h100001, 21'h100002, 21'h100002};
    logic        t4_gnt  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    video_rect_fill_engine #(.DW(9), .HMAX(640), .VMAX(480)) dut (
        .clk(clk), .reset(reset), .cs(cs), .write(write), .read(read),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .video_cs(video_cs), .video_wr(video_wr), .video_addr(video_addr),
        .video_wr_data(video_wr_data), .done_irq(done_irq)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reg_wr(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        tick();
        cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
    endtask

    task automatic corner(input logic [4:0] a, input int x, input int y);
        reg_wr(a, (32'(y) << 16) | 32'(x));
    endtask

    task automatic chk_bus(input string tag, input logic [20:0] a, input logic [31:0] d);
        chk({tag, "_cs"}, 32'({bus_req, video_cs, video_wr}), 32'h7);
        chk({tag, "_addr"}, 32'(video_addr), 32'(a));
        chk({tag, "_data"}, video_wr_data, d);
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; write = 1'b0; read = 1'b0; bus_gnt = 1'b0;
        addr = '0; wr_data = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_cs", 32'({bus_req, video_cs, video_wr}), 32'h0);
        chk("rst_addr", 32'(video_addr), 32'h0);
        chk("rst_data", video_wr_data, 32'h0);
        chk("rst_irq", 32'(done_irq), 32'h0);
        chk("rst_rd", rd_data, 32'h0);

        // 2x2 rectangle, continuous grant
        bus_gnt = 1'b1;
        corner(5'd0, 10, 20);
        corner(5'd1, 11, 21);
        reg_wr(5'd2, 32'h1AB);
        reg_wr(5'd3, 32'h1);
        chk("t1_setup_busy", rd_data, 32'h1);
        chk("t1_setup_cs", 32'(video_cs), 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk_bus("t1", t1_addr[i], 32'h0000_01AB);
            tick();
        end
        chk("t1_done_irq", 32'(done_irq), 32'h1);
        chk("t1_done_cs", 32'(video_cs), 32'h0);
        chk("t1_done_rd", rd_data, 32'h12);
        tick();
        chk("t1_sticky", 32'(done_irq), 32'h1);

        // Bottom-right corner, clipped to 2x2
        corner(5'd0, 638, 478);
        corner(5'd1, 700, 600);
        reg_wr(5'd3, 32'h1);
        chk("t2_irq_clr", 32'(done_irq), 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk_bus("t2", t2_addr[i], 32'h0000_01AB);
            tick();
        end
        chk("t2_done_rd", rd_data, 32'h12);
        tick();

        // Empty rectangle (x0 > x1): SETUP then DONE, no bus activity
        corner(5'd0, 50, 5);
        corner(5'd1, 40, 9);
        reg_wr(5'd3, 32'h1);
        chk("t3_setup_rd", rd_data, 32'h1);
        chk("t3_setup_cs", 32'(video_cs), 32'h0);
        tick();
        chk("t3_done_cs", 32'(video_cs), 32'h0);
        chk("t3_done_rd", rd_data, 32'h2);
        tick();
        chk("t3_irq", 32'(done_irq), 32'h1);
        chk("t3_idle_cs", 32'(video_cs), 32'h0);

        // 3x1 rectangle with grant stalls
        corner(5'd0, 0, 0);
        corner(5'd1, 2, 0);
        reg_wr(5'd2, 32'hF0);
        reg_wr(5'd3, 32'h1);
        tick();
        for (int i = 0; i < 6; i++) begin
            bus_gnt = t4_gnt[i];
            chk_bus("t4", t4_addr[i], 32'h0000_00F0);
            tick();
        end
        bus_gnt = 1'b1;
        chk("t4_done_cs", 32'(video_cs), 32'h0);
        chk("t4_done_rd", rd_data, 32'hE);
        tick();

        // Full screen, abort after 100 accepts with a grant in the abort cycle
        corner(5'd0, 0, 0);
        corner(5'd1, 639, 479);
        reg_wr(5'd3, 32'h1);
        tick();
        for (int i = 0; i < 100; i++) tick();
        chk("t5_pre_addr", 32'(video_addr), 32'h0010_0064);
        chk("t5_pre_rd", rd_data, 32'd401);
        reg_wr(5'd3, 32'h2);
        chk("t5_abort_rd", rd_data, 32'd404);
        chk("t5_abort_cs", 32'(video_cs), 32'h0);
        chk("t5_abort_irq", 32'(done_irq), 32'h0);
        tick();
        chk("t5_idle_cs", 32'(video_cs), 32'h0);

        // Corner0 written during RUN must not affect the next fill
        corner(5'd0, 10, 20);
        corner(5'd1, 11, 21);
        reg_wr(5'd2, 32'h1AB);
        reg_wr(5'd3, 32'h1);
        tick();
        corner(5'd0, 0, 0);
        tick(); tick(); tick();
        chk("t6_done_rd", rd_data, 32'h12);
        tick();
        reg_wr(5'd3, 32'h1);
        tick();
        chk_bus("t6_restart", 21'h10320A, 32'h0000_01AB);
        tick();
        chk("t6_mid_addr", 32'(video_addr), 32'h0010_320B);

        // Synchronous reset mid-RUN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t7_rst_cs", 32'({bus_req, video_cs, video_wr}), 32'h0);
        chk("t7_rst_rd", rd_data, 32'h0);
        chk("t7_rst_addr", 32'(video_addr), 32'h0);

        // Config registers cleared by reset: single pixel at (0,0), colour 0
        reg_wr(5'd3, 32'h1);
        tick();
        chk_bus("t7_px", 21'h100000, 32'h0);
        tick();
        chk("t7_done_rd", rd_data, 32'h6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
